// File: rtl/div_multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle divider control/writeback stage.
package div_multicycle_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCapture,
    StFast
  } state_e;

  localparam int unsigned MaxWidth = 64;

  // Most negative two's-complement value of the given width, LSB-aligned.
  function automatic logic [MaxWidth-1:0] min_neg(int unsigned width);
    return MaxWidth'(1) << (width - 1);
  endfunction

  localparam logic [MaxWidth-1:0] FastDbzQuot = '1;
  localparam logic [MaxWidth-1:0] FastOvfRem  = '0;

endpackage

// File: rtl/div_multicycle_ctrl_if.sv
// Handshake, operand and result signals between control unit, divider and this stage.
interface div_multicycle_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   op_dividend;
  logic [WIDTH-1:0]   op_divisor;
  logic [2*WIDTH-1:0] div_result;
  logic [WIDTH-1:0]   div_dividend;
  logic [WIDTH-1:0]   div_divisor;
  logic               busy;
  logic               done;
  logic               div_by_zero;
  logic               overflow;
  logic [WIDTH-1:0]   z_hi;
  logic [WIDTH-1:0]   z_lo;

  modport slave (
    input  start, abort, op_dividend, op_divisor, div_result,
    output div_dividend, div_divisor, busy, done, div_by_zero, overflow, z_hi, z_lo
  );

  modport master (
    output start, abort, op_dividend, op_divisor, div_result,
    input  div_dividend, div_divisor, busy, done, div_by_zero, overflow, z_hi, z_lo
  );
endinterface

// File: rtl/div_multicycle_ctrl.sv
// Holds operands on a combinational divider for a settle window, then writes back
// {remainder, quotient}; divide-by-zero and overflow bypass the divider.
module div_multicycle_ctrl
  import div_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  clear,
  div_multicycle_ctrl_if.slave  bus
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);
  localparam logic [MaxWidth-1:0] MinNegFull = min_neg(WIDTH);
  localparam logic [WIDTH-1:0] MinNeg  = MinNegFull[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DbzQuot = FastDbzQuot[WIDTH-1:0];
  localparam logic [WIDTH-1:0] OvfRem  = FastOvfRem[WIDTH-1:0];

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  dividend_q, dividend_d;
  logic [WIDTH-1:0]  divisor_q, divisor_d;
  logic [WIDTH-1:0]  z_hi_q, z_hi_d;
  logic [WIDTH-1:0]  z_lo_q, z_lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    z_hi_d     = z_hi_q;
    z_lo_d     = z_lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          dividend_d = bus.op_dividend;
          divisor_d  = bus.op_divisor;
          busy_d     = 1'b1;
          if (bus.op_divisor == '0 ||
              (bus.op_dividend == MinNeg && bus.op_divisor == '1)) begin
            state_d = StFast;
          end else begin
            cnt_d   = CntLoad;
            state_d = StSettle;
          end
        end
      end
      StSettle: begin
        if (bus.abort) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StCapture: begin
        busy_d  = 1'b0;
        state_d = StIdle;
        if (!bus.abort) begin
          z_hi_d = bus.div_result[2*WIDTH-1:WIDTH];
          z_lo_d = bus.div_result[WIDTH-1:0];
          dbz_d  = 1'b0;
          ovf_d  = 1'b0;
          done_d = 1'b1;
        end
      end
      StFast: begin
        busy_d  = 1'b0;
        state_d = StIdle;
        if (!bus.abort) begin
          done_d = 1'b1;
          // Fast path was taken, so a nonzero divisor here means overflow.
          if (divisor_q == '0) begin
            z_hi_d = dividend_q;
            z_lo_d = DbzQuot;
            dbz_d  = 1'b1;
            ovf_d  = 1'b0;
          end else begin
            z_hi_d = OvfRem;
            z_lo_d = MinNeg;
            dbz_d  = 1'b0;
            ovf_d  = 1'b1;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      z_hi_q     <= '0;
      z_lo_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      z_hi_q     <= z_hi_d;
      z_lo_q     <= z_lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.div_by_zero  = dbz_q;
  assign bus.overflow     = ovf_q;
  assign bus.z_hi         = z_hi_q;
  assign bus.z_lo         = z_lo_q;

endmodule

// File: tb/tb_div_multicycle_ctrl.sv
// Randomized and directed checks of div_multicycle_ctrl against a latency-level model.
module tb_div_multicycle_ctrl;

  localparam int unsigned W = 32;
  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  div_multicycle_ctrl_if #(.WIDTH(W)) bus ();

  div_multicycle_ctrl #(
    .WIDTH        (W),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (bus.slave)
  );

  // Behavioural divider; junk on the fast-path cases so a leak into Z is visible.
  function automatic logic [63:0] div_fn(logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return 64'hDEADBEEF_CAFEF00D;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 64'h0123_4567_89AB_CDEF;
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  assign bus.div_result = div_fn(bus.div_dividend, bus.div_divisor);

  int checks = 0;
  int failures = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: an op in flight completes a fixed number of edges after acceptance.
  bit          m_busy, m_done, m_dbz, m_ovf;
  int          m_left;
  logic [31:0] m_a, m_b, m_zhi, m_zlo;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_dbz = 0; m_ovf = 0; m_left = 0;
    m_a = '0; m_b = '0; m_zhi = '0; m_zlo = '0;
  endtask

  task automatic model_step(logic s, logic ab, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    bit fast;
    m_done = 0;
    if (!m_busy) begin
      if (s && !ab) begin
        fast   = (b == 0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        m_busy = 1;
        m_a    = a;
        m_b    = b;
        m_left = fast ? 1 : S + 1;
      end
    end else if (ab) begin
      m_busy = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
        sa = m_a;
        sb = m_b;
        if (m_b == 0) begin
          m_zhi = m_a; m_zlo = 32'hFFFF_FFFF; m_dbz = 1; m_ovf = 0;
        end else if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
          m_zhi = 32'd0; m_zlo = 32'h8000_0000; m_dbz = 0; m_ovf = 1;
        end else begin
          m_zhi = 32'(sa % sb); m_zlo = 32'(sa / sb); m_dbz = 0; m_ovf = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    check("busy", 64'(bus.busy), 64'(m_busy));
    check("done", 64'(bus.done), 64'(m_done));
    check("div_by_zero", 64'(bus.div_by_zero), 64'(m_dbz));
    check("overflow", 64'(bus.overflow), 64'(m_ovf));
    check("z_hi", 64'(bus.z_hi), 64'(m_zhi));
    check("z_lo", 64'(bus.z_lo), 64'(m_zlo));
    check("div_dividend", 64'(bus.div_dividend), 64'(m_a));
    check("div_divisor", 64'(bus.div_divisor), 64'(m_b));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(logic s, logic ab, logic [31:0] a, logic [31:0] b);
    bus.start = s;
    bus.abort = ab;
    bus.op_dividend = a;
    bus.op_divisor = b;
    model_step(s, ab, a, b);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_clear();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #3 clear = 1'b0;
    #1;
    model_reset();
    check("clr_busy", 64'(bus.busy), 64'd0);
    check("clr_z_lo", 64'(bus.z_lo), 64'd0);
    check("clr_div_dividend", 64'(bus.div_dividend), 64'd0);
    check_all();
    @(negedge clk);
    clear = 1'b1;
  endtask

  initial begin
    int busy_cnt;
    logic [31:0] a, b;
    logic s, ab;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op_dividend = '0;
    bus.op_divisor = '0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(negedge clk);
    clear = 1'b1;

    // 100 / 7 with latency measured via busy
    cycle(1'b1, 1'b0, 32'd100, 32'd7);
    busy_cnt = int'(bus.busy);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 32'd0);
      busy_cnt += int'(bus.busy);
      if (i == 4) check("norm_done_pulse", 64'(bus.done), 64'd1);
    end
    check("norm_busy_cycles", 64'(busy_cnt), 64'd5);
    check("norm_z_hi", 64'(bus.z_hi), 64'd2);
    check("norm_z_lo", 64'(bus.z_lo), 64'd14);

    // -100 / 7
    cycle(1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7);
    idle(6);
    check("neg_z_lo", 64'(bus.z_lo), 64'hFFFF_FFF2);
    check("neg_z_hi", 64'(bus.z_hi), 64'hFFFF_FFFE);

    // 55 / 0
    cycle(1'b1, 1'b0, 32'd55, 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 32'd0);
    check("dbz_done", 64'(bus.done), 64'd1);
    check("dbz_z_hi", 64'(bus.z_hi), 64'd55);
    check("dbz_z_lo", 64'(bus.z_lo), 64'hFFFF_FFFF);
    check("dbz_flag", 64'(bus.div_by_zero), 64'd1);
    idle(1);

    // MIN_NEG / -1
    cycle(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 32'd0, 32'd0);
    check("ovf_z_lo", 64'(bus.z_lo), 64'h8000_0000);
    check("ovf_z_hi", 64'(bus.z_hi), 64'd0);
    check("ovf_flag", 64'(bus.overflow), 64'd1);
    idle(1);

    // Abort in the second settle cycle, then a clean restart
    cycle(1'b1, 1'b0, 32'd100, 32'd7);
    cycle(1'b0, 1'b0, 32'd0, 32'd0);
    cycle(1'b0, 1'b1, 32'd0, 32'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_z_lo_kept", 64'(bus.z_lo), 64'h8000_0000);
    idle(6);
    cycle(1'b1, 1'b0, 32'd100, 32'd7);
    idle(6);
    check("restart_z_lo", 64'(bus.z_lo), 64'd14);

    // start held high: ignored while busy, accepted in the done cycle
    cycle(1'b1, 1'b0, 32'd1000, 32'd10);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'd77, 32'd3);
    check("b2b_busy_again", 64'(bus.busy), 64'd1);
    check("b2b_first_z_lo", 64'(bus.z_lo), 64'd100);
    idle(6);
    check("b2b_second_z_lo", 64'(bus.z_lo), 64'd25);

    // Asynchronous clear mid-settle
    cycle(1'b1, 1'b0, 32'd100, 32'd7);
    cycle(1'b0, 1'b0, 32'd0, 32'd0);
    do_clear();
    idle(2);

    // Randomized traffic with biased corner operands
    for (int n = 0; n < 1500; n++) begin
      s  = ($urandom_range(0, 99) < 60);
      ab = ($urandom_range(0, 99) < 5);
      a  = $urandom();
      b  = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        4: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      cycle(s, ab, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
